rvr32_cmp_seq: RTL

Parametrised, multi-cycle successor to the single-cycle branch comparator. It accepts two WIDTH-bit operands and a 3-bit branch compare opcode over a valid/ready handshake. It scans the operands SLICE bits per cycle from MSB to LSB and returns the 1-bit branch decision over a second valid/ready handshake. It sits between operand read and branch resolution in narrow-datapath and low-area Rover32 configurations.

---
 rtl/rvr32_cmp_pkg.sv | 19 +
 rtl/rvr32_cmp_slice.sv | 15 +
 rtl/rvr32_cmp_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rvr32_cmp_pkg.sv
// Shared opcode constants, FSM state type and result helper for the sequential branch comparator.
// Combinational only: no latency and no handshake.
package rvr32_cmp_pkg;

    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BGE  = 3'b101;
    localparam logic [2:0] CMP_BLTU = 3'b110;
    localparam logic [2:0] CMP_BGEU = 3'b111;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Bit 2 selects less-than over equality; bit 0 inverts the chosen result.
    function automatic logic cmp_result(input logic [2:0] op, input logic lt, input logic eq);
        return (op[2] ? lt : eq) ^ op[0];
    endfunction

endpackage

// File: rtl/rvr32_cmp_slice.sv
// Unsigned compare of one SLICE-bit operand slice.
// Combinational with no latency; it has no handshake and applies no backpressure.
module rvr32_cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/rvr32_cmp_seq.sv
// Sequential branch comparator that scans SLICE bits per cycle from the MSB. Latency is 2..NSL+1 cycles with RVR32_CMP_SEQ_EARLY_EN and a fixed NSL+1 otherwise.
// Accepts one operation at a time, with no overlap; the result is held in DONE until out_ready.
module rvr32_cmp_seq
    import rvr32_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [2:0]       cmpop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             data_out
);

    localparam int NSL = WIDTH / SLICE;
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op1, op2;
    logic [2:0]       op_r;
    logic [IW-1:0]    idx;
    logic [SLICE-1:0] s1, s2;
    logic             s_eq, s_lt;
    logic             decide, lt_v, eq_v;
    logic [WIDTH-1:0] flip;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign flip = {~cmpop[1], {(WIDTH-1){1'b0}}};

    assign s1 = op1[idx*SLICE +: SLICE];
    assign s2 = op2[idx*SLICE +: SLICE];

    rvr32_cmp_slice #(.SLICE(SLICE)) u_slice (
        .a  (s1),
        .b  (s2),
        .eq (s_eq),
        .lt (s_lt)
    );

`ifdef RVR32_CMP_SEQ_EARLY_EN
    assign decide = !s_eq || (idx == '0);
    assign lt_v   = s_lt;
    assign eq_v   = s_eq;
`else
    // Full scan: the first differing slice from the top is remembered until the last slice.
    logic found, lt_l;

    assign decide = (idx == '0);
    assign lt_v   = found ? lt_l : s_lt;
    assign eq_v   = !found && s_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            found <= 1'b0;
            lt_l  <= 1'b0;
        end else if (state == IDLE) begin
            found <= 1'b0;
        end else if (state == SCAN && !found && !s_eq) begin
            found <= 1'b1;
            lt_l  <= s_lt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = SCAN;
            SCAN:    if (decide)    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1      <= '0;
            op2      <= '0;
            op_r     <= '0;
            idx      <= '0;
            data_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op1  <= data_in1 ^ flip;
                        op2  <= data_in2 ^ flip;
                        op_r <= cmpop;
                        idx  <= IW'(NSL - 1);
                    end
                end
                SCAN: begin
                    if (decide) begin
                        data_out <= cmp_result(op_r, lt_v, eq_v);
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
